// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer:
// FSM state encodings, forward-select codes and register address width.
package pipe_pkg;

   localparam int REG_AW      = 3;
   localparam int MEM_TMO_DEF = 15;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_ERROR    = 2'b10
   } state_t;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;

   // The younger producer (EXE/MEM) holds the newer value, so it wins over MEM/WB.
   function automatic logic [1:0] fwd_pick(input logic from_mem, input logic from_wb);
      if (from_mem)
         return FWD_EXMEM;
      else if (from_wb)
         return FWD_MEMWB;
      else
         return FWD_REGFILE;
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Single source/destination register match, qualified by source use,
// destination write enable, and the hard-wired-zero R0.
module hazard_cmp
   import pipe_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic              src_use,
   input  logic [REG_AW-1:0] dst,
   input  logic              dst_wr_en,
   output logic              hit
);

   assign hit = src_use & dst_wr_en & (dst != '0) & (src == dst);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline buffer sequencer: enables/flushes, forward selects, mem-wait freeze and timeout.
// Build option HAZARD_FWD_EN: operand forwarding (load-use stall only); otherwise RAW stalls.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TMO = MEM_TMO_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_use,
   input  logic              id_rs2_use,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_wr_en,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_wr_en,
   input  logic              ex_br_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [1:0]        state,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int WAIT_W = $clog2(MEM_TMO + 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   logic       stall_hz;
   logic [1:0] fwd_a_raw, fwd_b_raw;
   logic       hold, run_ok;

`ifdef HAZARD_FWD_EN
   logic ld_a, ld_b, fa_mem, fa_wb, fb_mem, fb_wb;

   hazard_cmp u_ld_a  (.src(id_rs1), .src_use(id_rs1_use), .dst(ex_rd),  .dst_wr_en(ex_wr_en),  .hit(ld_a));
   hazard_cmp u_ld_b  (.src(id_rs2), .src_use(id_rs2_use), .dst(ex_rd),  .dst_wr_en(ex_wr_en),  .hit(ld_b));
   hazard_cmp u_fa_mem(.src(ex_rs1), .src_use(1'b1),       .dst(mem_rd), .dst_wr_en(mem_wr_en), .hit(fa_mem));
   hazard_cmp u_fa_wb (.src(ex_rs1), .src_use(1'b1),       .dst(wb_rd),  .dst_wr_en(wb_wr_en),  .hit(fa_wb));
   hazard_cmp u_fb_mem(.src(ex_rs2), .src_use(1'b1),       .dst(mem_rd), .dst_wr_en(mem_wr_en), .hit(fb_mem));
   hazard_cmp u_fb_wb (.src(ex_rs2), .src_use(1'b1),       .dst(wb_rd),  .dst_wr_en(wb_wr_en),  .hit(fb_wb));

   assign stall_hz  = ex_is_load & (ld_a | ld_b);
   assign fwd_a_raw = fwd_pick(fa_mem, fa_wb);
   assign fwd_b_raw = fwd_pick(fb_mem, fb_wb);
`else
   logic ex_a, ex_b, mem_a, mem_b;
   logic unused_fwd_inputs;

   hazard_cmp u_ex_a (.src(id_rs1), .src_use(id_rs1_use), .dst(ex_rd),  .dst_wr_en(ex_wr_en),  .hit(ex_a));
   hazard_cmp u_ex_b (.src(id_rs2), .src_use(id_rs2_use), .dst(ex_rd),  .dst_wr_en(ex_wr_en),  .hit(ex_b));
   hazard_cmp u_mem_a(.src(id_rs1), .src_use(id_rs1_use), .dst(mem_rd), .dst_wr_en(mem_wr_en), .hit(mem_a));
   hazard_cmp u_mem_b(.src(id_rs2), .src_use(id_rs2_use), .dst(mem_rd), .dst_wr_en(mem_wr_en), .hit(mem_b));

   // Without forwarding every in-flight producer must drain before ID can read it.
   assign stall_hz          = ex_a | ex_b | mem_a | mem_b;
   assign fwd_a_raw         = FWD_REGFILE;
   assign fwd_b_raw         = FWD_REGFILE;
   assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_wr_en, ex_is_load};
`endif

   always_ff @(posedge clock) begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
   end

   // mem_req/mem_ready: the MEM access completes in the cycle both are high;
   // mem_req with mem_ready low freezes the whole pipe until mem_ready rises.
   // The cycle mem_ready rises is a normal RUN cycle, so a branch held in EXE
   // during the wait is flushed then.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      hold          = 1'b0;
      run_ok        = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               hold       = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               run_ok = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               run_ok     = 1'b1;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               hold = 1'b1;
               if (wait_cnt_q == WAIT_W'(MEM_TMO)) begin
                  state_d       = ST_ERROR;
                  mem_timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         default: hold = 1'b1;
      endcase

      pc_en      = !hold;
      ifid_en    = !hold;
      idex_en    = !hold;
      exmem_en   = !hold;
      memwb_en   = !hold;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (run_ok && ex_br_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (run_ok && stall_hz) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;

      stall_d = stall_q;
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);

      if (reset) begin
         pc_en         = 1'b1;
         ifid_en       = 1'b1;
         idex_en       = 1'b1;
         exmem_en      = 1'b1;
         memwb_en      = 1'b1;
         ifid_flush    = 1'b1;
         idex_flush    = 1'b1;
         fwd_a_sel     = FWD_REGFILE;
         fwd_b_sel     = FWD_REGFILE;
         state_d       = ST_RUN;
         wait_cnt_d    = '0;
         mem_timeout_d = 1'b0;
         stall_d       = '0;
      end
   end

   assign state        = state_q;
   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model; honours HAZARD_FWD_EN like the design.
module tb_pipeline_hazard_ctrl;

   localparam int W       = 14;
   localparam int MEM_TMO = 15;

   logic       clock;
   logic       reset;
   logic [2:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_rs1_use, id_rs2_use, ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
   logic       ex_br_taken, mem_req, mem_ready;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
   logic [1:0] fwd_a_sel, fwd_b_sel, state;
   logic       mem_timeout;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   // behavioural model state: 0 running, 1 waiting on memory, 2 dead
   int m_mode   = 0;
   int m_waited = 0;
   int m_stalls = 0;
   bit m_tmo    = 0;

   pipeline_hazard_ctrl dut (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
      .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
      .wb_rd(wb_rd), .wb_wr_en(wb_wr_en), .ex_br_taken(ex_br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit reads(int rs, bit used, int rd, bit we);
      return used && we && (rd != 0) && (rs == rd);
   endfunction

   function automatic int fwd_for(int rs);
`ifdef HAZARD_FWD_EN
      if (mem_wr_en && mem_rd != 0 && int'(mem_rd) == rs) return 1;
      if (wb_wr_en && wb_rd != 0 && int'(wb_rd) == rs) return 2;
`endif
      return 0;
   endfunction

   function automatic bit id_must_wait();
      bit on_ex, on_mem;
      on_ex  = reads(id_rs1, id_rs1_use, ex_rd, ex_wr_en) || reads(id_rs2, id_rs2_use, ex_rd, ex_wr_en);
      on_mem = reads(id_rs1, id_rs1_use, mem_rd, mem_wr_en) || reads(id_rs2, id_rs2_use, mem_rd, mem_wr_en);
`ifdef HAZARD_FWD_EN
      return ex_is_load && on_ex;
`else
      return on_ex || on_mem;
`endif
   endfunction

   // driver tasks
   task automatic drive_idle();
      reset = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wr_en = 0; ex_is_load = 0;
      mem_rd = 0; mem_wr_en = 0; wb_rd = 0; wb_wr_en = 0;
      ex_br_taken = 0; mem_req = 0; mem_ready = 1;
   endtask

   task automatic drive_random(input bit starve);
      id_rs1 = 3'($urandom_range(0, 7)); id_rs2 = 3'($urandom_range(0, 7));
      id_rs1_use = 1'($urandom_range(0, 1)); id_rs2_use = 1'($urandom_range(0, 1));
      ex_rs1 = 3'($urandom_range(0, 7)); ex_rs2 = 3'($urandom_range(0, 7));
      ex_rd = 3'($urandom_range(0, 7)); ex_wr_en = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      mem_rd = 3'($urandom_range(0, 7)); mem_wr_en = 1'($urandom_range(0, 1));
      wb_rd = 3'($urandom_range(0, 7)); wb_wr_en = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 4) == 0);
      mem_req = starve ? 1'b1 : ($urandom_range(0, 3) == 0);
      mem_ready = starve ? 1'b0 : ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 79) == 0);
   endtask

   // one cycle: predict, compare on the falling edge, advance the model
   task automatic step();
      logic [4:0] en;
      logic [1:0] fl;
      int fa, fb;
      bit frozen;
      logic [W-1:0] exp_v, got_v;

      fa = 0; fb = 0;
      frozen = (m_mode == 2) || (m_mode == 1 && !mem_ready) || (m_mode == 0 && mem_req && !mem_ready);
      if (reset) begin
         en = 5'b11111; fl = 2'b11;
      end else begin
         fa = fwd_for(ex_rs1);
         fb = fwd_for(ex_rs2);
         if (frozen) begin
            en = 5'b00000; fl = 2'b00;
         end else if (ex_br_taken) begin
            en = 5'b11111; fl = 2'b11;
         end else if (id_must_wait()) begin
            en = 5'b00111; fl = 2'b01;
         end else begin
            en = 5'b11111; fl = 2'b00;
         end
      end
      exp_v = {en, fl, 2'(fa), 2'(fb), 2'(m_mode), m_tmo};
      exp_q.push_back(exp_v);

      @(negedge clock);
      got_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               fwd_a_sel, fwd_b_sel, state, mem_timeout};
      check("ctl", 32'(got_v), 32'(exp_q.pop_front()));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));

      if (reset) begin
         m_mode = 0; m_waited = 0; m_stalls = 0; m_tmo = 0;
      end else begin
         if (!en[4] && m_stalls < 65535) m_stalls++;
         if (m_mode == 0 && mem_req && !mem_ready) begin
            m_mode = 1; m_waited = 1;
         end else if (m_mode == 1) begin
            if (mem_ready) begin
               m_mode = 0; m_waited = 0;
            end else if (m_waited == MEM_TMO) begin
               m_mode = 2; m_tmo = 1;
            end else begin
               m_waited++;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      drive_idle();
      reset = 1;
      @(posedge clock);
      #1;
      step();
      drive_idle();
      step();

      // load-use: LOAD r3 in EXE, ADD r4,r3,r1 in ID, then the bubble reaches EXE
      ex_rd = 3; ex_wr_en = 1; ex_is_load = 1;
      id_rs1 = 3; id_rs1_use = 1; id_rs2 = 1; id_rs2_use = 1;
      step();
      ex_wr_en = 0; ex_is_load = 0; ex_rd = 0;
      step();

      // forwarding from MEM beats WB, then WB alone
      drive_idle();
      mem_rd = 2; mem_wr_en = 1; wb_rd = 2; wb_wr_en = 1; ex_rs1 = 2; ex_rs2 = 2;
      step();
      mem_wr_en = 0;
      step();

      // memory wait with ready low, then release
      drive_idle();
      mem_req = 1; mem_ready = 0;
      repeat (4) step();
      mem_ready = 1;
      step();
      drive_idle();
      step();

      // branch beats load-use; R0 destination neither stalls nor forwards
      ex_rd = 3; ex_wr_en = 1; ex_is_load = 1; id_rs1 = 3; id_rs1_use = 1; ex_br_taken = 1;
      step();
      drive_idle();
      ex_rd = 0; ex_wr_en = 1; ex_is_load = 1; id_rs1 = 0; id_rs1_use = 1;
      mem_rd = 0; mem_wr_en = 1; ex_rs1 = 0; wb_rd = 0; wb_wr_en = 1;
      step();

      // branch held across a memory wait, acted on when ready arrives
      drive_idle();
      ex_br_taken = 1; mem_req = 1; mem_ready = 0;
      repeat (2) step();
      mem_ready = 1;
      step();

      // RAW on MEM result, then on EXE result
      drive_idle();
      mem_rd = 5; mem_wr_en = 1; id_rs1 = 5; id_rs1_use = 1;
      step();
      mem_wr_en = 0; ex_rd = 5; ex_wr_en = 1;
      step();
      mem_wr_en = 1; ex_wr_en = 0;
      step();

      // timeout into ERROR, ready no longer helps, reset recovers
      drive_idle();
      mem_req = 1; mem_ready = 0;
      repeat (MEM_TMO + 3) step();
      mem_ready = 1;
      repeat (2) step();
      reset = 1;
      step();
      drive_idle();
      step();

      // random traffic with periodic memory starvation
      for (int i = 0; i < 800; i++) begin
         drive_random((i % 200) >= 120 && (i % 200) < 140);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
